// File: rtl/ldl_ram_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ldl_ram_arb2
//  Purpose  : Two-requester round-robin arbiter in front of a single RAM port
//             (registered read, 1-cycle latency, read-before-write). After
//             reset an optional sweep writes INIT_VAL to every address before
//             requests are accepted.
//  Ports    : clk, rst             - clock, asynchronous active-high reset
//             init_done            - high once the sweep is complete
//             reqN/weN/addrN/dinN  - requester N request, write flag, address,
//                                    write data (N = 0, 1)
//             gntN                 - combinational grant (transfer on reqN&gntN)
//             rvldN/rdataN         - read data valid (registered) and data
//             ram_re/ram_we        - RAM read / write enables
//             ram_addr/ram_din     - RAM address / write data
//             ram_dout             - RAM registered read data
//  Revision : 1.0 - initial release
// ============================================================================
module ldl_ram_arb2 #(
    parameter int unsigned       DWIDTH   = 8,
    parameter int unsigned       AWIDTH   = 4,
    parameter int unsigned       INIT_EN  = 1,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              req0,
    input  logic              we0,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [DWIDTH-1:0] din0,
    input  logic              req1,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvld0,
    output logic              rvld1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              ram_re,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // With INIT_EN cleared the block comes out of reset ready to serve.
    localparam state_t            RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    // All-ones is DEPTH-1, the final address written by the sweep.
    localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                rvld0_q, rvld0_d;
    logic                rvld1_q, rvld1_d;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_ram_re;
    logic                w_ram_we;
    logic [AWIDTH-1:0]   w_ram_addr;
    logic [DWIDTH-1:0]   w_ram_din;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rvld0_d    = 1'b0;
        rvld1_d    = 1'b0;
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_ram_re   = 1'b0;
        w_ram_we   = 1'b0;
        w_ram_addr = '0;
        w_ram_din  = '0;
        case (state_q)
            ST_INIT: begin
                w_ram_we   = 1'b1;
                w_ram_addr = cnt_q;
                w_ram_din  = INIT_VAL;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // On a tie the requester that was not served last wins.
                w_gnt0 = req0 & (~req1 | last_q);
                w_gnt1 = req1 & ~w_gnt0;
                if (w_gnt0) begin
                    last_d     = 1'b0;
                    w_ram_addr = addr0;
                    w_ram_din  = din0;
                    w_ram_we   = we0;
                    w_ram_re   = ~we0;
                    rvld0_d    = ~we0;
                end else if (w_gnt1) begin
                    last_d     = 1'b1;
                    w_ram_addr = addr1;
                    w_ram_din  = din1;
                    w_ram_we   = we1;
                    w_ram_re   = ~we1;
                    rvld1_d    = ~we1;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            rvld0_q <= 1'b0;
            rvld1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rvld0_q <= rvld0_d;
            rvld1_q <= rvld1_d;
        end
    end

    // Grants, enables and init_done are masked by rst so nothing reaches the
    // RAM or the requesters while reset is held, even when the reset state
    // is RUN.
    assign init_done = (state_q == ST_RUN) & ~rst;
    assign gnt0      = w_gnt0 & ~rst;
    assign gnt1      = w_gnt1 & ~rst;
    assign ram_re    = w_ram_re & ~rst;
    assign ram_we    = w_ram_we & ~rst;
    assign ram_addr  = w_ram_addr;
    assign ram_din   = w_ram_din;

    assign rvld0     = rvld0_q;
    assign rvld1     = rvld1_q;
    // The RAM output register holds the data for the cycle after the read.
    assign rdata0    = ram_dout;
    assign rdata1    = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_ldl_ram_arb2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ldl_ram_arb2
//  Purpose  : Self-checking bench for ldl_ram_arb2 with a behavioural RAM and
//             a transaction-level reference model (shadow memory, last-served
//             index, pending read data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldl_ram_arb2;

    localparam int          DEPTH = 16;
    localparam logic [7:0]  IV    = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] din0 = '0, din1 = '0;

    logic       init_done, gnt0, gnt1, rvld0, rvld1, ram_re, ram_we;
    logic [7:0] rdata0, rdata1, ram_din;
    logic [3:0] ram_addr;
    logic [7:0] ram_dout = '0;

    logic       ni_init_done, ni_gnt0, ni_gnt1, ni_rvld0, ni_rvld1, ni_ram_re, ni_ram_we;
    logic [7:0] ni_rdata0, ni_rdata1, ni_ram_din;
    logic [3:0] ni_ram_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         m_run;
    int         m_cnt;
    int         m_last;
    bit         m_pend0, m_pend1;
    logic [7:0] m_pd0, m_pd1;
    logic [7:0] shadow [DEPTH];

    logic [7:0] mem [DEPTH];

    always #5 clk = ~clk;

    ldl_ram_arb2 #(.DWIDTH(8), .AWIDTH(4), .INIT_EN(1), .INIT_VAL(IV)) u_dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
        .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .rvld0(rvld0), .rvld1(rvld1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    ldl_ram_arb2 #(.DWIDTH(8), .AWIDTH(4), .INIT_EN(0), .INIT_VAL(IV)) u_dut_ni (
        .clk(clk), .rst(rst), .init_done(ni_init_done),
        .req0(req0), .we0(we0), .addr0(addr0), .din0(din0),
        .req1(req1), .we1(we1), .addr1(addr1), .din1(din1),
        .gnt0(ni_gnt0), .gnt1(ni_gnt1), .rvld0(ni_rvld0), .rvld1(ni_rvld1),
        .rdata0(ni_rdata0), .rdata1(ni_rdata1),
        .ram_re(ni_ram_re), .ram_we(ni_ram_we), .ram_addr(ni_ram_addr), .ram_din(ni_ram_din),
        .ram_dout(8'h00)
    );

    // Behavioural RAM: registered read, read-before-write on the same address.
    always @(posedge clk) begin
        if (ram_re) ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    // Expected grant from the arbitration rules and the current inputs.
    function automatic void exp_grant(output bit e0, output bit e1);
        int winner;
        e0 = 1'b0;
        e1 = 1'b0;
        if (!m_run || rst) return;
        if (req0 && req1) winner = (m_last + 1) % 2;
        else if (req0)    winner = 0;
        else if (req1)    winner = 1;
        else              winner = -1;
        e0 = (winner == 0);
        e1 = (winner == 1);
    endfunction

    task automatic model_release();
        rst     = 1'b0;
        m_run   = 1'b0;
        m_cnt   = 0;
        m_last  = 1;
        m_pend0 = 1'b0;
        m_pend1 = 1'b0;
    endtask

    // Advance one clock, applying the accepted transfer to the model.
    task automatic model_step();
        bit e0, e1;
        exp_grant(e0, e1);
        @(posedge clk);
        if (!m_run) begin
            shadow[m_cnt] = IV;
            if (m_cnt == DEPTH - 1) m_run = 1'b1;
            m_cnt   = (m_cnt + 1) % DEPTH;
            m_pend0 = 1'b0;
            m_pend1 = 1'b0;
        end else begin
            m_pend0 = e0 && !we0;
            m_pend1 = e1 && !we1;
            m_pd0   = shadow[addr0];
            m_pd1   = shadow[addr1];
            if (e0) begin m_last = 0; if (we0) shadow[addr0] = din0; end
            if (e1) begin m_last = 1; if (we1) shadow[addr1] = din1; end
        end
        #1;
    endtask

    task automatic test_reset();
        req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
        n_checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b%b expected 00", gnt0, gnt1); end
        n_checks++; if (ram_we !== 1'b0 || ram_re !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got we=%b re=%b expected 0 0", ram_we, ram_re); end
        n_checks++; if (rvld0 !== 1'b0 || rvld1 !== 1'b0) begin n_fail++; $display("FAIL rst_rvld: got %b%b expected 00", rvld0, rvld1); end
        n_checks++; if (ni_init_done !== 1'b0 || ni_gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_noinit: got done=%b gnt0=%b expected 0 0", ni_init_done, ni_gnt0); end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    // Sweep with req1 held throughout; it must be served on the first RUN cycle.
    task automatic test_init_sweep();
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
        model_release();
        for (int i = 0; i < DEPTH; i++) begin
            #2;
            n_checks++; if (ram_we !== 1'b1 || ram_re !== 1'b0) begin n_fail++; $display("FAIL sweep_en cyc %0d: got we=%b re=%b expected 1 0", i, ram_we, ram_re); end
            n_checks++; if (ram_addr !== 4'(i) || ram_din !== IV) begin n_fail++; $display("FAIL sweep_bus cyc %0d: got addr=%h din=%h expected %h %h", i, ram_addr, ram_din, 4'(i), IV); end
            n_checks++; if (init_done !== 1'b0 || gnt1 !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL sweep_hold cyc %0d: got done=%b gnt=%b%b expected 0 00", i, init_done, gnt0, gnt1); end
            model_step();
        end
        #2;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL sweep_done: got %b expected 1", init_done); end
        n_checks++; if (gnt1 !== 1'b1 || ram_re !== 1'b1 || ram_addr !== 4'd7) begin n_fail++; $display("FAIL sweep_first_gnt: got gnt1=%b re=%b addr=%h expected 1 1 7", gnt1, ram_re, ram_addr); end
        model_step();
    endtask

    // Both requesters held as reads: alternating grants starting with 0.
    task automatic test_tie();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'(($urandom % 8) * 2);
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'(($urandom % 8) * 2 + 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin req0 = 1'b0; req1 = 1'b0; end
            #2;
            if (i < 4) begin
                n_checks++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin n_fail++; $display("FAIL tie_gnt cyc %0d: got %b%b expected %b%b", i, gnt0, gnt1, i % 2 == 0, i % 2 == 1); end
            end
            if (i >= 1) begin
                n_checks++; if (rvld0 !== ((i - 1) % 2 == 0) || rvld1 !== ((i - 1) % 2 == 1)) begin n_fail++; $display("FAIL tie_rvld cyc %0d: got %b%b expected %b%b", i, rvld0, rvld1, (i - 1) % 2 == 0, (i - 1) % 2 == 1); end
                n_checks++; if ((m_pend0 && rdata0 !== m_pd0) || (m_pend1 && rdata1 !== m_pd1)) begin n_fail++; $display("FAIL tie_rdata cyc %0d: got %h/%h expected %h/%h", i, rdata0, rdata1, m_pd0, m_pd1); end
            end
            model_step();
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; din0 = 8'hA5;
        #2;
        n_checks++; if (gnt0 !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'd3 || ram_din !== 8'hA5) begin n_fail++; $display("FAIL wr_bus: got gnt0=%b we=%b addr=%h din=%h expected 1 1 3 a5", gnt0, ram_we, ram_addr, ram_din); end
        model_step();
        we0 = 1'b0;
        #2;
        n_checks++; if (gnt0 !== 1'b1 || ram_re !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL rd_bus: got gnt0=%b re=%b we=%b expected 1 1 0", gnt0, ram_re, ram_we); end
        model_step();
        req0 = 1'b0;
        #2;
        n_checks++; if (rvld0 !== 1'b1 || rdata0 !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got rvld0=%b rdata0=%h expected 1 a5", rvld0, rdata0); end
        model_step();
        #2;
        n_checks++; if (rvld0 !== 1'b0) begin n_fail++; $display("FAIL rd_single: got rvld0=%b expected 0", rvld0); end
        model_step();
    endtask

    // Random traffic; a request not granted is held unchanged.
    task automatic test_random();
        bit hold0 = 1'b0, hold1 = 1'b0;
        bit e0, e1;
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                req0 = ($urandom % 4) != 0; we0 = $urandom % 2;
                addr0 = 4'($urandom); din0 = 8'($urandom);
            end
            if (!hold1) begin
                req1 = ($urandom % 4) != 0; we1 = $urandom % 2;
                addr1 = 4'($urandom); din1 = 8'($urandom);
            end
            #2;
            exp_grant(e0, e1);
            n_checks++; if (gnt0 !== e0 || gnt1 !== e1) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %b%b expected %b%b", i, gnt0, gnt1, e0, e1); end
            if (e0) begin
                n_checks++; if (ram_we !== we0 || ram_re !== !we0 || ram_addr !== addr0 || ram_din !== din0) begin n_fail++; $display("FAIL rnd_bus0 cyc %0d: got we=%b re=%b a=%h d=%h expected %b %b %h %h", i, ram_we, ram_re, ram_addr, ram_din, we0, !we0, addr0, din0); end
            end else if (e1) begin
                n_checks++; if (ram_we !== we1 || ram_re !== !we1 || ram_addr !== addr1 || ram_din !== din1) begin n_fail++; $display("FAIL rnd_bus1 cyc %0d: got we=%b re=%b a=%h d=%h expected %b %b %h %h", i, ram_we, ram_re, ram_addr, ram_din, we1, !we1, addr1, din1); end
            end else begin
                n_checks++; if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_addr !== 4'h0 || ram_din !== 8'h00) begin n_fail++; $display("FAIL rnd_idle cyc %0d: got we=%b re=%b a=%h d=%h expected 0 0 0 00", i, ram_we, ram_re, ram_addr, ram_din); end
            end
            n_checks++; if (rvld0 !== m_pend0 || rvld1 !== m_pend1) begin n_fail++; $display("FAIL rnd_rvld cyc %0d: got %b%b expected %b%b", i, rvld0, rvld1, m_pend0, m_pend1); end
            if (m_pend0) begin
                n_checks++; if (rdata0 !== m_pd0) begin n_fail++; $display("FAIL rnd_rdata0 cyc %0d: got %h expected %h", i, rdata0, m_pd0); end
            end
            if (m_pend1) begin
                n_checks++; if (rdata1 !== m_pd1) begin n_fail++; $display("FAIL rnd_rdata1 cyc %0d: got %h expected %h", i, rdata1, m_pd1); end
            end
            hold0 = req0 && !e0;
            hold1 = req1 && !e1;
            model_step();
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    // Reset asserted right after the edge that accepts a read.
    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        #2;
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b expected 1", gnt0); end
        model_step();
        rst = 1'b1; req0 = 1'b0;
        #2;
        n_checks++; if (rvld0 !== 1'b0 || init_done !== 1'b0) begin n_fail++; $display("FAIL rmid_rvld: got rvld0=%b done=%b expected 0 0", rvld0, init_done); end
        @(posedge clk); #1;
        model_release();
        #2;
        n_checks++; if (rvld0 !== 1'b0) begin n_fail++; $display("FAIL rmid_rvld_after: got %b expected 0", rvld0); end
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 4'd0 || init_done !== 1'b0) begin n_fail++; $display("FAIL rmid_sweep: got we=%b addr=%h done=%b expected 1 0 0", ram_we, ram_addr, init_done); end
        repeat (DEPTH) model_step();
        #2;
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL rmid_done: got %b expected 1", init_done); end
        model_step();
    endtask

    task automatic test_no_init();
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; din0 = 8'h5A; req1 = 1'b0;
        #2;
        n_checks++; if (ni_init_done !== 1'b0 || ni_gnt0 !== 1'b0 || ni_ram_we !== 1'b0) begin n_fail++; $display("FAIL ni_rst: got done=%b gnt0=%b we=%b expected 0 0 0", ni_init_done, ni_gnt0, ni_ram_we); end
        @(posedge clk); #1;
        model_release();
        #2;
        n_checks++; if (ni_init_done !== 1'b1 || ni_gnt0 !== 1'b1) begin n_fail++; $display("FAIL ni_first: got done=%b gnt0=%b expected 1 1", ni_init_done, ni_gnt0); end
        n_checks++; if (ni_ram_we !== 1'b1 || ni_ram_addr !== 4'd5 || ni_ram_din !== 8'h5A) begin n_fail++; $display("FAIL ni_bus: got we=%b a=%h d=%h expected 1 5 5a", ni_ram_we, ni_ram_addr, ni_ram_din); end
        n_checks++; if (gnt0 !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 4'd0) begin n_fail++; $display("FAIL ni_main_sweep: got gnt0=%b we=%b a=%h expected 0 1 0", gnt0, ram_we, ram_addr); end
        model_step();
        req0 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 8'($urandom);
            shadow[i] = 8'hxx;
        end
        test_reset();
        test_init_sweep();
        test_tie();
        test_write_read();
        test_random();
        test_reset_mid();
        test_no_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
